keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Matrix keypad scanner for the countdown timer's time-entry path; the input-side counterpart of the multiplexed 7-seg driver.
//  - Walks a zero-hot row strobe across the keypad and samples the active-low column lines.
//  - Debounces whole scan frames and emits one 4-bit key code with a single-cycle VALID strobe per press.
//  - Sits between the board keypad pins and the timer set/edit FSM.
// PARAMETERS
//  ROWS         4  number of row strobes; ROWS*COLS <= 16 (elaboration error otherwise)
//  COLS         4  number of column inputs
//  DEB_SCANS    4  consecutive identical frames needed to accept a change (1..15)
//  SYNC_STAGES  2  column synchroniser depth (>= 2)
// PORTS
//  CLK    in   1     system clock, all logic on rising edge
//  CLR    in   1     synchronous, active-high reset
//  CE     in   1     scan-step enable (1-cycle tick from the shared prescaler); one row per tick
//  COL    in   COLS  raw column lines, active-low, asynchronous, pulled up on board
//  ROW    out  ROWS  row strobe, zero-hot (exactly one bit low)
//  KEY    out  4     last accepted key code = row_idx*COLS + col_idx
//  VALID  out  1     1-cycle pulse: KEY has just been updated by an accepted press
//  HELD   out  1     level: debounced "a single key is down"
// BEHAVIOUR
//  Reset (CLR=1 at a rising edge):
//   - ROW = ~1 (row 0 low); KEY = 0; VALID = 0; HELD = 0.
//   - Row index, frame accumulator, stable counter and sync flops cleared.
//   - prev_code and debounced code = NONE.
//   - A frame in progress is discarded.
//  Synchroniser: COL passes through SYNC_STAGES flops before use. CE period >= SYNC_STAGES+2 cycles (integration constraint).
//  Scan step, on each cycle with CE=1:
//   - Sample synced COL for the row currently low, then rotate ROW to the next row (row ROWS-1 wraps to row 0).
//   - CE=0: ROW, accumulators and counters hold.
//  Frame accumulation, per row sample:
//   - Count low columns, saturating at 2.
//   - Record the code of the first low bit (lowest row, then lowest column).
//  Frame end (CE on row ROWS-1, after including that row's sample):
//   - frame_code = recorded code if exactly one key down.
//   - frame_code = NONE if zero keys, or two or more keys (ghost/chord rejected).
//  Debounce:
//   - frame_code == prev_code: stable_cnt increments, saturating at DEB_SCANS.
//   - Otherwise: stable_cnt = 1 and prev_code = frame_code.
//   - stable_cnt reaches DEB_SCANS (transition edge only) and frame_code != debounced code: accept.
//  Accept of a key k:
//   - KEY <= k, HELD <= 1, VALID = 1 for exactly the next cycle.
//   - Applies to a direct roll k1->k2 without release, which also pulses VALID.
//  Accept of NONE: HELD <= 0; KEY holds its last value; no VALID.
//  Latency: a clean press is accepted at the frame end of the DEB_SCANS-th consecutive identical frame.
//   - VALID is registered: high the cycle after that frame-end CE.
//  Holding a key never re-pulses VALID (no auto-repeat).
//  VALID is never high on two consecutive cycles.
// STRUCTURE
//  - Shared include keypad_defs.vh: KEY_W=4, CODE_NONE (5-bit code with MSB set), frame-code width.
//  - Sub-module: RING_CNT (BITS_NUM=ROWS, ACT_STATE=0) generates ROW, clocked by CLK/CLR/CE.
//  - Row index: separate binary counter kept in lockstep with the ring.
//  - Remainder stays in this file: sync chain, frame accumulator, debounce counter, output regs.
// TESTING (ROWS=COLS=4, DEB_SCANS=4, CE every 8 CLK; a frame = 32 CLK)
//  1. CLR held 2 cycles:
//     -> ROW=4'b1110, KEY=0, VALID=0, HELD=0; after 1 CE ROW=4'b1101.
//     -> with CE=0, ROW frozen.
//  2. Key r2c1 held 6 frames (COL=4'b1101 while ROW=4'b1011):
//     -> one VALID at end of frame 4, KEY=4'h9, HELD=1.
//     -> release 4 frames -> HELD=0, KEY stays 9, no VALID.
//  3. Bounce: key 9 present/absent on alternating frames for 5 frames, then stable:
//     -> no VALID until 4 consecutive stable frames, then exactly one VALID, KEY=9.
//  4. Chord: keys 5 and 6 both held -> no VALID, HELD=0.
//     -> release 6 (5 held) -> VALID after 4 frames, KEY=5.
//  5. Roll: 9 accepted, then A pressed as 9 is released, no empty frame:
//     -> second VALID after 4 frames, KEY=4'hA, HELD stays 1.
//  6. CLR asserted after 2 stable frames of key 3:
//     -> outputs at reset values; key 3 still held needs 4 full new frames before VALID, KEY=3.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared key-code definitions for the keypad scanner.
// Codes are KEY_W bits plus an MSB that marks "no key / rejected frame".
// Also holds the saturating counter helper used by the frame accumulator.
package keypad_scan_pkg;

    localparam int KEY_W  = 4;
    localparam int CODE_W = KEY_W + 1;
    localparam logic [CODE_W-1:0] CODE_NONE = {1'b1, {KEY_W{1'b0}}};

    // Adds two hit counts and saturates at 2 ("two or more keys").
    function automatic logic [1:0] sat2_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd2) ? 2'd2 : s[1:0];
    endfunction

endpackage

// File: rtl/keypad_scan_ring_cnt.sv
// Rotating one-hot/one-cold ring: one position advances per CE.
// Latency: output follows the register, updated on the CE edge.
// No backpressure; CE=0 simply freezes the ring.
module keypad_scan_ring_cnt #(
    parameter int BITS_NUM  = 4,
    parameter bit ACT_STATE = 1'b0
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    output logic [BITS_NUM-1:0] Q
);

    logic [BITS_NUM-1:0] onehot;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            onehot <= BITS_NUM'(1);
        end else if (CE) begin
            onehot <= (onehot << 1) | (onehot >> (BITS_NUM - 1));
        end
    end

    assign Q = ACT_STATE ? onehot : ~onehot;

endmodule

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: zero-hot row strobe, frame debounce, one VALID per press.
// Latency: accept at the frame-end CE of the DEB_SCANS-th identical frame; VALID the cycle after.
// No backpressure: VALID is a single-cycle strobe, the consumer must take it when it fires.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int DEB_SCANS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CE,
    input  logic [COLS-1:0]  COL,
    output logic [ROWS-1:0]  ROW,
    output logic [KEY_W-1:0] KEY,
    output logic             VALID,
    output logic             HELD
);

    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);
    localparam logic [3:0] DEB_MAX = 4'(DEB_SCANS);

    generate
        if (ROWS * COLS > 16) begin : g_bad_size
            $error("keypad_scan: ROWS*COLS must not exceed 16");
        end
        if (DEB_SCANS < 1 || DEB_SCANS > 15) begin : g_bad_deb
            $error("keypad_scan: DEB_SCANS must be 1..15");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("keypad_scan: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [COLS-1:0]   sync_q [SYNC_STAGES];
    logic [RIDX_W-1:0] row_idx;
    logic [1:0]        acc_hits;
    logic [CODE_W-1:0] acc_code;
    logic [CODE_W-1:0] prev_code;
    logic [CODE_W-1:0] deb_code;
    logic [3:0]        stable_cnt;

    logic [COLS-1:0]   col_low;
    logic [1:0]        row_hits;
    logic [1:0]        frame_hits;
    logic [CODE_W-1:0] row_code;
    logic [CODE_W-1:0] first_code;
    logic [CODE_W-1:0] frame_code;
    logic              frame_end;
    logic              same_code;
    logic              reached;
    logic              accept;

    keypad_scan_ring_cnt #(
        .BITS_NUM  (ROWS),
        .ACT_STATE (1'b0)
    ) u_ring (
        .CLK (CLK),
        .CLR (CLR),
        .CE  (CE),
        .Q   (ROW)
    );

    // Column lines idle high through the pull-ups, so the chain resets to that level.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= COL;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Lowest row wins by keeping the accumulated code once any hit is recorded.
    always_comb begin
        col_low  = ~sync_q[SYNC_STAGES-1];
        row_hits = 2'd0;
        row_code = CODE_NONE;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_low[c]) row_code = CODE_W'(int'(row_idx) * COLS + c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_low[c]) row_hits = sat2_add(row_hits, 2'd1);
        end
        frame_hits = sat2_add(acc_hits, row_hits);
        first_code = (acc_hits == 2'd0) ? row_code : acc_code;
        frame_code = (frame_hits == 2'd1) ? first_code : CODE_NONE;
    end

    assign frame_end = CE && (row_idx == LAST_ROW);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            row_idx  <= '0;
            acc_hits <= 2'd0;
            acc_code <= CODE_NONE;
        end else if (CE) begin
            if (frame_end) begin
                row_idx  <= '0;
                acc_hits <= 2'd0;
                acc_code <= CODE_NONE;
            end else begin
                row_idx  <= row_idx + RIDX_W'(1);
                acc_hits <= frame_hits;
                acc_code <= first_code;
            end
        end
    end

    // Accept only on the frame where the stable run first reaches DEB_SCANS.
    always_comb begin
        same_code = (frame_code == prev_code);
        reached   = same_code ? (stable_cnt == DEB_MAX - 4'd1) : (DEB_SCANS == 1);
        accept    = frame_end && reached && (frame_code != deb_code);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            prev_code  <= CODE_NONE;
            deb_code   <= CODE_NONE;
            stable_cnt <= 4'd0;
            KEY        <= '0;
            HELD       <= 1'b0;
            VALID      <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (frame_end) begin
                if (same_code) begin
                    if (stable_cnt != DEB_MAX) stable_cnt <= stable_cnt + 4'd1;
                end else begin
                    stable_cnt <= 4'd1;
                    prev_code  <= frame_code;
                end
            end
            if (accept) begin
                deb_code <= frame_code;
                HELD     <= ~frame_code[CODE_W-1];
                if (!frame_code[CODE_W-1]) begin
                    KEY   <= frame_code[KEY_W-1:0];
                    VALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical keypad model drives COL from ROW and a pressed-key mask,
// and a frame-level reference model predicts VALID/KEY/HELD.
// CE ticks every 8 cycles; masks change only on frame boundaries.
module tb_keypad_scan;

    localparam int NONE = 16;
    localparam int DEB  = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        ce  = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        valid;
    logic        held;
    logic [15:0] pressed = '0;

    int errors = 0;
    int checks = 0;

    int m_prev;
    int m_run;
    int m_deb;
    int m_key;
    bit m_held;

    always #5 clk = ~clk;

    keypad_scan #(
        .ROWS        (4),
        .COLS        (4),
        .DEB_SCANS   (DEB),
        .SYNC_STAGES (2)
    ) dut (
        .CLK   (clk),
        .CLR   (clr),
        .CE    (ce),
        .COL   (col),
        .ROW   (row),
        .KEY   (key),
        .VALID (valid),
        .HELD  (held)
    );

    // A pressed key shorts its column to the row currently driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (row[r] === 1'b0 && pressed[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    function automatic int frame_key(input logic [15:0] m);
        if ($countones(m) != 1) return NONE;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return NONE;
    endfunction

    task automatic model_reset();
        m_prev = NONE;
        m_run  = 0;
        m_deb  = NONE;
        m_key  = 0;
        m_held = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        ce  = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    // One CE tick sampling row r; checks the ring advance and VALID right after the edge.
    task automatic step(input string tag, input int r, input bit exp_valid);
        logic [3:0] exp_row;
        repeat (7) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        exp_row = ~(4'(1) << ((r + 1) % 4));
        checks++;
        if (row !== exp_row)
            $display("FAIL %s row-strobe after row %0d: got %b want %b", tag, r, row, exp_row);
        if (row !== exp_row) errors++;
        checks++;
        if (valid !== exp_valid) begin
            errors++;
            $display("FAIL %s VALID after row %0d: got %b want %b", tag, r, valid, exp_valid);
        end
    endtask

    task automatic run_frame(input logic [15:0] mask, input string tag);
        int fc;
        bit acc;
        bit exp_v;
        pressed = mask;
        fc = frame_key(mask);
        if (fc == m_prev) m_run++;
        else begin
            m_run  = 1;
            m_prev = fc;
        end
        acc   = (m_run == DEB) && (fc != m_deb);
        exp_v = acc && (fc != NONE);
        if (acc) begin
            m_deb = fc;
            if (fc != NONE) begin
                m_key  = fc;
                m_held = 1'b1;
            end else begin
                m_held = 1'b0;
            end
        end
        for (int r = 0; r < 4; r++) step(tag, r, (r == 3) ? exp_v : 1'b0);
        checks++;
        if (key !== 4'(m_key)) begin
            errors++;
            $display("FAIL %s KEY: got %h want %h", tag, key, 4'(m_key));
        end
        checks++;
        if (held !== m_held) begin
            errors++;
            $display("FAIL %s HELD: got %b want %b", tag, held, m_held);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (row !== 4'b1110 || key !== 4'h0 || valid !== 1'b0 || held !== 1'b0) begin
            errors++;
            $display("FAIL %s reset outputs: got ROW=%b KEY=%h VALID=%b HELD=%b want 1110/0/0/0",
                     tag, row, key, valid, held);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
        repeat (10) @(negedge clk);
        checks++;
        if (row !== 4'b1110) begin
            errors++;
            $display("FAIL reset_freeze ROW: got %b want 1110", row);
        end
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        checks++;
        if (row !== 4'b1101) begin
            errors++;
            $display("FAIL reset_first_ce ROW: got %b want 1101", row);
        end
        do_reset();
    endtask

    task automatic test_press();
        for (int f = 0; f < 6; f++) run_frame(16'h0200, "press9");
        for (int f = 0; f < 4; f++) run_frame(16'h0000, "release9");
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 5; f++) run_frame((f % 2 == 0) ? 16'h0200 : 16'h0000, "bounce");
        for (int f = 0; f < 5; f++) run_frame(16'h0200, "bounce_stable");
        for (int f = 0; f < 4; f++) run_frame(16'h0000, "bounce_release");
    endtask

    task automatic test_chord();
        for (int f = 0; f < 5; f++) run_frame(16'h0060, "chord56");
        for (int f = 0; f < 5; f++) run_frame(16'h0020, "chord_keep5");
        for (int f = 0; f < 4; f++) run_frame(16'h0000, "chord_release");
    endtask

    task automatic test_back_to_back_roll();
        for (int f = 0; f < 4; f++) run_frame(16'h0200, "roll9");
        for (int f = 0; f < 5; f++) run_frame(16'h0400, "rollA");
        for (int f = 0; f < 4; f++) run_frame(16'h0000, "roll_release");
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 2; f++) run_frame(16'h0008, "pre_clr3");
        step("partial3", 0, 1'b0);
        step("partial3", 1, 1'b0);
        do_reset();
        check_reset_outputs("mid_reset");
        for (int f = 0; f < 5; f++) run_frame(16'h0008, "post_clr3");
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int kind;
        int k1;
        int k2;
        int hold;
        do_reset();
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 3);
            k1   = $urandom_range(0, 15);
            k2   = (k1 + $urandom_range(1, 15)) % 16;
            mask = '0;
            if (kind == 1 || kind == 2) mask[k1] = 1'b1;
            if (kind == 3) begin
                mask[k1] = 1'b1;
                mask[k2] = 1'b1;
            end
            hold = $urandom_range(1, 6);
            for (int f = 0; f < hold; f++) run_frame(mask, "random");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press();
        test_bounce();
        test_chord();
        test_back_to_back_roll();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
